// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage multiply/divide sequencer.
//   state_t         : sequencer state, 2-bit encoded
//   md_op_t         : operands and sign latched at accept
//   DIV0_LO         : LO value written for a divide by zero
//   TIMEOUT_CYC_DEF : default RUN-cycle limit before forced retire
package muldiv_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned TIMEOUT_CYC_DEF = 64;

  localparam logic [XLEN-1:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic            sgn;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } md_op_t;

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared multi-cycle multiplier/divider in EX.
// Accepts one mul/div at a time, runs the selected unit's start/ready
// handshake, holds the EX stall and emits one HI/LO write on retire.
// Divide-by-zero, flush and timeout are resolved here.
// Ports:
//   clk, rst                         clock, async active-high reset
//   op_valid/op_div/op_signed        EX instruction request and kind
//   op_a, op_b                       rs / rt operands
//   ex_advance, flush                EX leaves stage / annul operation
//   mul_start/signed/a/b, mul_ready, mul_result   multiplier handshake
//   div_start/signed/annul/a/b, div_ready, div_result  divider handshake
//   stallreq, busy                   EX stall request / not idle
//   hilo_we, hi_wdata, lo_wdata      HI/LO write bundle
//   md_err                           pulse on a timed-out retire
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic        op_div,
  input  logic        op_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        ex_advance,
  input  logic        flush,
  output logic        mul_start,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_ready,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        stallreq,
  output logic        busy,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        md_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;
  // Counter value in the last allowed RUN cycle (counter is 0 in the first).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t            state;
  state_t            state_nxt;
  md_op_t            op_r;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   hi_r;
  logic [XLEN-1:0]   lo_r;
  logic              err_r;

  logic accept;
  logic div_zero;
  logic in_run;
  logic run_rdy;
  logic timeout;

  // Handshake qualifiers shared by next-state and datapath.
  always_comb begin
    accept   = (state == IDLE) & op_valid & ~flush;
    div_zero = op_div & (op_b == '0);
    in_run   = (state == MUL_RUN) | (state == DIV_RUN);
    run_rdy  = ((state == MUL_RUN) & mul_ready) | ((state == DIV_RUN) & div_ready);
    // A ready arriving in the last allowed cycle still wins over timeout.
    timeout  = in_run & ~run_rdy & (cnt == CNT_LAST);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; flush overrides every state.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            if (div_zero)    state_nxt = DONE;
            else if (op_div) state_nxt = DIV_RUN;
            else             state_nxt = MUL_RUN;
          end
        end
        MUL_RUN, DIV_RUN: begin
          if (run_rdy | timeout) state_nxt = DONE;
        end
        DONE: begin
          if (ex_advance) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Operand latch, RUN counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r  <= '0;
      cnt   <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
      err_r <= 1'b0;
    end else if (accept) begin
      op_r  <= '{sgn: op_signed, a: op_a, b: op_b};
      cnt   <= '0;
      err_r <= 1'b0;
      if (div_zero) begin
        hi_r <= op_a;
        lo_r <= DIV0_LO;
      end
    end else if (in_run & ~flush) begin
      if (run_rdy) begin
        {hi_r, lo_r} <= (state == DIV_RUN) ? div_result : mul_result;
      end else if (timeout) begin
        hi_r  <= '0;
        lo_r  <= '0;
        err_r <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Outputs; everything idles at 0 outside the state that drives it.
  always_comb begin
    mul_start  = 1'b0;
    mul_signed = 1'b0;
    mul_a      = '0;
    mul_b      = '0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_annul  = 1'b0;
    div_a      = '0;
    div_b      = '0;
    hilo_we    = 1'b0;
    hi_wdata   = '0;
    lo_wdata   = '0;
    md_err     = 1'b0;
    busy       = (state != IDLE);
    // Gated by rst so a held op_valid cannot stall EX during reset.
    stallreq   = ~rst & op_valid & ~flush & (state != DONE);
    case (state)
      MUL_RUN: begin
        mul_start  = ~flush;
        mul_signed = op_r.sgn;
        mul_a      = op_r.a;
        mul_b      = op_r.b;
      end
      DIV_RUN: begin
        div_start  = ~flush;
        div_signed = op_r.sgn;
        div_annul  = flush;
        div_a      = op_r.a;
        div_b      = op_r.b;
      end
      DONE: begin
        hilo_we  = ex_advance & ~flush;
        hi_wdata = hi_r;
        lo_wdata = lo_r;
        md_err   = ex_advance & ~flush & err_r;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: two instances (default timeout and
// TIMEOUT_CYC = 8) share stimulus; op_sel routes op_valid to one of them.
module tb_muldiv_ctrl;

  typedef struct {
    bit          div;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    int          k;      // RUN cycles without ready before the ready cycle
    bit          rdy2;   // hold ready one extra cycle with junk data
    int          wadv;   // DONE cycles before ex_advance
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_sel, op_div, op_signed, ex_advance, flush;
  logic        mul_ready, div_ready;
  logic [31:0] op_a, op_b;
  logic [63:0] mul_result, div_result;
  logic        v_in [2];

  logic        mul_start [2], mul_signed [2], div_start [2], div_signed [2];
  logic        div_annul [2], stallreq [2], busy [2], hilo_we [2], md_err [2];
  logic [31:0] mul_a [2], mul_b [2], div_a [2], div_b [2];
  logic [31:0] hi_wdata [2], lo_wdata [2];

  int n_pass = 0;
  int n_total = 0;

  assign v_in[0] = op_valid & ~op_sel;
  assign v_in[1] = op_valid & op_sel;

  always #5 clk = ~clk;

  muldiv_ctrl #(.TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .op_valid(v_in[0]), .op_div(op_div), .op_signed(op_signed),
    .op_a(op_a), .op_b(op_b), .ex_advance(ex_advance), .flush(flush),
    .mul_start(mul_start[0]), .mul_signed(mul_signed[0]), .mul_a(mul_a[0]), .mul_b(mul_b[0]),
    .mul_ready(mul_ready), .mul_result(mul_result),
    .div_start(div_start[0]), .div_signed(div_signed[0]), .div_annul(div_annul[0]),
    .div_a(div_a[0]), .div_b(div_b[0]), .div_ready(div_ready), .div_result(div_result),
    .stallreq(stallreq[0]), .busy(busy[0]), .hilo_we(hilo_we[0]),
    .hi_wdata(hi_wdata[0]), .lo_wdata(lo_wdata[0]), .md_err(md_err[0])
  );

  muldiv_ctrl #(.TIMEOUT_CYC(8)) dut_to (
    .clk(clk), .rst(rst), .op_valid(v_in[1]), .op_div(op_div), .op_signed(op_signed),
    .op_a(op_a), .op_b(op_b), .ex_advance(ex_advance), .flush(flush),
    .mul_start(mul_start[1]), .mul_signed(mul_signed[1]), .mul_a(mul_a[1]), .mul_b(mul_b[1]),
    .mul_ready(mul_ready), .mul_result(mul_result),
    .div_start(div_start[1]), .div_signed(div_signed[1]), .div_annul(div_annul[1]),
    .div_a(div_a[1]), .div_b(div_b[1]), .div_ready(div_ready), .div_result(div_result),
    .stallreq(stallreq[1]), .busy(busy[1]), .hilo_we(hilo_we[1]),
    .hi_wdata(hi_wdata[1]), .lo_wdata(lo_wdata[1]), .md_err(md_err[1])
  );

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    else n_pass++;
  endfunction

  // Architectural result of an operation, from plain arithmetic.
  function automatic logic [63:0] arith(bit d, bit s, logic [31:0] a, logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    if (!d) return s ? 64'(sa * sb) : 64'(ua * ub);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) return {32'(sa % sb), 32'(sa / sb)};
    return {32'(ua % ub), 32'(ua / ub)};
  endfunction

  function automatic int lim(int i);
    return (i == 0) ? 64 : 8;
  endfunction

  // Model: 0 = idle, 1 = unit running, 2 = result waiting for retire.
  int          m_mode [2];
  int          m_cnt  [2];
  bit          m_div  [2], m_sgn [2], m_err [2];
  logic [31:0] m_a [2], m_b [2], m_hi [2], m_lo [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_mode[i] <= 0; m_cnt[i] <= 0; m_err[i] <= 1'b0; m_div[i] <= 1'b0;
        m_sgn[i] <= 1'b0; m_a[i] <= '0; m_b[i] <= '0; m_hi[i] <= '0; m_lo[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (flush) m_mode[i] <= 0;
        else if (m_mode[i] == 0) begin
          if (v_in[i]) begin
            m_div[i] <= op_div; m_sgn[i] <= op_signed;
            m_a[i] <= op_a; m_b[i] <= op_b; m_err[i] <= 1'b0; m_cnt[i] <= 0;
            if (op_div && op_b == 32'd0) begin
              m_mode[i] <= 2;
              {m_hi[i], m_lo[i]} <= arith(1'b1, op_signed, op_a, op_b);
            end else m_mode[i] <= 1;
          end
        end else if (m_mode[i] == 1) begin
          if (m_div[i] ? div_ready : mul_ready) begin
            m_mode[i] <= 2;
            {m_hi[i], m_lo[i]} <= arith(m_div[i], m_sgn[i], m_a[i], m_b[i]);
          end else if (m_cnt[i] + 1 == lim(i)) begin
            m_mode[i] <= 2; m_hi[i] <= '0; m_lo[i] <= '0; m_err[i] <= 1'b1;
          end else m_cnt[i] <= m_cnt[i] + 1;
        end else if (ex_advance) m_mode[i] <= 0;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin : cmp
    logic       mr, dr, dn;
    logic [8:0] e_ctl, a_ctl;
    for (int i = 0; i < 2; i++) begin
      mr = (m_mode[i] == 1) && !m_div[i];
      dr = (m_mode[i] == 1) && m_div[i];
      dn = (m_mode[i] == 2);
      e_ctl = {m_mode[i] != 0, !rst && v_in[i] && !flush && m_mode[i] != 2,
               mr && !flush, mr && m_sgn[i], dr && !flush, dr && m_sgn[i],
               dr && flush, dn && ex_advance && !flush,
               dn && ex_advance && !flush && m_err[i]};
      a_ctl = {busy[i], stallreq[i], mul_start[i], mul_signed[i], div_start[i],
               div_signed[i], div_annul[i], hilo_we[i], md_err[i]};
      chk($sformatf("i%0d ctl{busy,stall,ms,msg,ds,dsg,annul,we,err}", i), 64'(a_ctl), 64'(e_ctl));
      chk($sformatf("i%0d mul_ab", i), {mul_a[i], mul_b[i]}, mr ? {m_a[i], m_b[i]} : 64'd0);
      chk($sformatf("i%0d div_ab", i), {div_a[i], div_b[i]}, dr ? {m_a[i], m_b[i]} : 64'd0);
      chk($sformatf("i%0d hilo", i), {hi_wdata[i], lo_wdata[i]}, dn ? {m_hi[i], m_lo[i]} : 64'd0);
    end
  end

  // Event counters for directed per-operation expectations.
  int          n_stall [2], n_start [2], n_annul [2], n_we [2], n_err [2];
  logic [31:0] cap_hi [2], cap_lo [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        n_stall[i] <= 0; n_start[i] <= 0; n_annul[i] <= 0; n_we[i] <= 0; n_err[i] <= 0;
        cap_hi[i] <= '0; cap_lo[i] <= '0;
      end else begin
        if (stallreq[i]) n_stall[i] <= n_stall[i] + 1;
        if (mul_start[i] || div_start[i]) n_start[i] <= n_start[i] + 1;
        if (div_annul[i]) n_annul[i] <= n_annul[i] + 1;
        if (md_err[i]) n_err[i] <= n_err[i] + 1;
        if (hilo_we[i]) begin
          n_we[i] <= n_we[i] + 1; cap_hi[i] <= hi_wdata[i]; cap_lo[i] <= lo_wdata[i];
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Runs one op on instance sel; called at posedge+1, returns at posedge+1.
  task automatic run_op(input vec_t v, input int sel, input string nm);
    int s_stall, s_start, s_we, s_err;
    bit dz;
    dz = v.div && (v.b == 32'd0);
    s_stall = n_stall[sel]; s_start = n_start[sel]; s_we = n_we[sel]; s_err = n_err[sel];
    op_valid = 1'b1; op_sel = sel[0]; op_div = v.div; op_signed = v.sgn;
    op_a = v.a; op_b = v.b;
    cyc();
    op_a = ~v.a; op_b = v.b ^ 32'h55;
    if (dz) chk({nm, " dz done at T+1 {busy,stall}"}, 64'({busy[sel], stallreq[sel]}), 64'(2'b10));
    else begin
      repeat (v.k) cyc();
      if (v.div) begin div_ready = 1'b1; div_result = {v.hi, v.lo}; end
      else       begin mul_ready = 1'b1; mul_result = {v.hi, v.lo}; end
      cyc();
      if (v.rdy2) begin
        mul_result = 64'hDEAD_BEEF_0BAD_F00D; div_result = 64'hDEAD_BEEF_0BAD_F00D;
        cyc();
      end
      mul_ready = 1'b0; div_ready = 1'b0; mul_result = '0; div_result = '0;
    end
    repeat (v.wadv) cyc();
    ex_advance = 1'b1;
    cyc();
    ex_advance = 1'b0; op_valid = 1'b0;
    chk({nm, " stall cycles"}, 64'(n_stall[sel] - s_stall), dz ? 64'd1 : 64'(v.k + 2));
    chk({nm, " start cycles"}, 64'(n_start[sel] - s_start), dz ? 64'd0 : 64'(v.k + 1));
    chk({nm, " hilo_we count"}, 64'(n_we[sel] - s_we), 64'd1);
    chk({nm, " md_err count"}, 64'(n_err[sel] - s_err), 64'd0);
    chk({nm, " hi/lo written"}, {cap_hi[sel], cap_lo[sel]}, {v.hi, v.lo});
  endtask

  initial begin : stim
    vec_t v;
    int   s0, s1, s2, s3, s4;
    rst = 1'b1; op_valid = 1'b0; op_sel = 1'b0; op_div = 1'b0; op_signed = 1'b0;
    op_a = '0; op_b = '0; ex_advance = 1'b0; flush = 1'b0;
    mul_ready = 1'b0; div_ready = 1'b0; mul_result = '0; div_result = '0;
    cyc();
    op_valid = 1'b1;
    cyc();
    chk("reset stallreq gated", 64'(stallreq[0]), 64'd0);
    op_valid = 1'b0; rst = 1'b0;
    cyc();
    chk("post-reset busy/we", 64'({busy[0], hilo_we[0], busy[1]}), 64'd0);

    v = '{div:0, sgn:1, a:32'hFFFF_FFFE, b:32'd3, k:4, rdy2:0, wadv:0,
          hi:32'hFFFF_FFFF, lo:32'hFFFF_FFFA};
    run_op(v, 0, "MULT -2*3");
    v = '{div:1, sgn:0, a:32'd100, b:32'd7, k:32, rdy2:0, wadv:0, hi:32'd2, lo:32'd14};
    run_op(v, 0, "DIVU 100/7 back-to-back");
    v = '{div:1, sgn:1, a:32'd5, b:32'd0, k:0, rdy2:0, wadv:2, hi:32'd5, lo:32'hFFFF_FFFF};
    run_op(v, 0, "DIV 5/0");
    v = '{div:0, sgn:0, a:32'hFFFF_FFFF, b:32'hFFFF_FFFF, k:0, rdy2:1, wadv:0,
          hi:32'hFFFF_FFFE, lo:32'h0000_0001};
    run_op(v, 0, "MULTU max*max double ready");
    v = '{div:1, sgn:1, a:32'hFFFF_FFF9, b:32'd2, k:3, rdy2:0, wadv:1,
          hi:32'hFFFF_FFFF, lo:32'hFFFF_FFFD};
    run_op(v, 0, "DIV -7/2");
    v = '{div:0, sgn:1, a:32'h8000_0000, b:32'd2, k:1, rdy2:0, wadv:0,
          hi:32'hFFFF_FFFF, lo:32'h0000_0000};
    run_op(v, 0, "MULT min*2");

    // Flush in the 10th DIV RUN cycle, late ready must be dropped.
    s0 = n_annul[0]; s1 = n_we[0]; s2 = n_start[0];
    op_valid = 1'b1; op_sel = 1'b0; op_div = 1'b1; op_signed = 1'b1;
    op_a = 32'd1000; op_b = 32'd3;
    cyc();
    repeat (9) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0; op_valid = 1'b0;
    chk("flush idle next cycle", 64'(busy[0]), 64'd0);
    repeat (4) cyc();
    div_ready = 1'b1; div_result = {32'd1, 32'd333};
    cyc();
    div_ready = 1'b0; div_result = '0;
    repeat (2) cyc();
    chk("flush annul pulses", 64'(n_annul[0] - s0), 64'd1);
    chk("flush no hilo_we", 64'(n_we[0] - s1), 64'd0);
    chk("flush start cycles", 64'(n_start[0] - s2), 64'd9);

    // Timeout on the TIMEOUT_CYC = 8 instance; the unit never answers.
    s0 = n_start[1]; s1 = n_stall[1]; s2 = n_we[1]; s3 = n_err[1];
    op_valid = 1'b1; op_sel = 1'b1; op_div = 1'b0; op_signed = 1'b0;
    op_a = 32'd3; op_b = 32'd4;
    cyc();
    repeat (7) cyc();
    chk("timeout still running at RUN 8", 64'(mul_start[1]), 64'd1);
    cyc();
    chk("timeout DONE {busy,stall}", 64'({busy[1], stallreq[1]}), 64'(2'b10));
    ex_advance = 1'b1;
    cyc();
    ex_advance = 1'b0; op_valid = 1'b0; op_sel = 1'b0;
    chk("timeout start cycles", 64'(n_start[1] - s0), 64'd8);
    chk("timeout stall cycles", 64'(n_stall[1] - s1), 64'd9);
    chk("timeout hilo_we count", 64'(n_we[1] - s2), 64'd1);
    chk("timeout md_err count", 64'(n_err[1] - s3), 64'd1);
    chk("timeout hi/lo", {cap_hi[1], cap_lo[1]}, 64'd0);

    // Reset mid MUL_RUN drops start/stall/busy without a clock edge.
    op_valid = 1'b1; op_div = 1'b0; op_signed = 1'b1; op_a = 32'd7; op_b = 32'd5;
    cyc();
    cyc();
    #2 rst = 1'b1;
    #1;
    chk("async reset {start,stall,busy,annul}",
        64'({mul_start[0], stallreq[0], busy[0], div_annul[0]}), 64'd0);
    cyc();
    cyc();
    op_valid = 1'b0; rst = 1'b0;
    cyc();
    v = '{div:0, sgn:0, a:32'd3, b:32'd4, k:2, rdy2:0, wadv:0, hi:32'd0, lo:32'd12};
    run_op(v, 0, "MULTU 3*4 after reset");
    s4 = 0;
    repeat (3) cyc();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
